// File: rtl/pipe_adder_sat_pkg.sv
// Shared constants and helpers for the pipelined saturating adder.
// Parameters are validated here so every instantiation applies the same rules.
package pipe_adder_sat_pkg;

  localparam logic SUB_OP = 1'b1;

  // Upper bound on WIDTH for the saturation constant helpers below.
  localparam int unsigned SAT_MAX_WIDTH = 256;

  function automatic logic [SAT_MAX_WIDTH-1:0] sat_max_val(input int unsigned w);
    logic [SAT_MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i + 1 < w; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [SAT_MAX_WIDTH-1:0] sat_min_val(input int unsigned w);
    logic [SAT_MAX_WIDTH-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  function automatic bit stage_split_ok(input int unsigned w, input int unsigned s);
    return (w >= 2) && (w <= SAT_MAX_WIDTH) && (s != 0) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_sat_adder_chunk.sv
// N-bit ripple-carry chunk built from FullAdder cells; purely combinational.
// cmsb_o is the carry into the chunk MSB, needed for signed overflow.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk
  import pipe_adder_sat_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    FullAdder u_fa (
      .a   (a_i[i]),
      .b   (b_i[i]),
      .cin (c[i]),
      .s   (sum_o[i]),
      .cout(c[i+1])
    );
  end

  assign cout_o = c[N];
  assign cmsb_o = c[N-1];
endmodule

// File: rtl/pipe_adder_sat.sv
// Pipelined add/subtract with optional signed saturation and valid/ready flow control.
// The carry chain is resolved STAGE_BITS per register stage; all stages stall together.
module pipe_adder_sat
  import pipe_adder_sat_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / STAGE_BITS;

  if (!stage_split_ok(WIDTH, STAGE_BITS)) begin : g_bad_params
    $error("pipe_adder_sat: STAGE_BITS must divide WIDTH and WIDTH must be >= 2");
  end

  localparam logic [SAT_MAX_WIDTH-1:0] SAT_MAX_FULL = sat_max_val(WIDTH);
  localparam logic [SAT_MAX_WIDTH-1:0] SAT_MIN_FULL = sat_min_val(WIDTH);
  localparam logic [WIDTH-1:0]         SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]         SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic             sub;
    logic             sat;
  } stage_t;

  // Slot 0 is the input capture register, slot k+1 holds the result of chunk k,
  // so a result leaves STAGES edges after acceptance with no path from a to sum.
  stage_t [STAGES:0] stage_q;
  stage_t [STAGES:0] stage_d;
  stage_t            in_d;
  logic              adv;

  assign adv      = !(stage_q[STAGES].vld && !out_ready);
  assign in_ready = adv && !rst;

  always_comb begin
    in_d     = '0;
    in_d.vld = in_valid;
    in_d.a   = a;
    in_d.b   = (sub == SUB_OP) ? ~b : b;
    in_d.c   = (sub == SUB_OP);
    in_d.sub = sub;
    in_d.sat = sat_en;
  end

  assign stage_d[0] = in_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t                cur;
    stage_t                nxt;
    logic [STAGE_BITS-1:0] csum;
    logic                  cco;
    logic                  cmsb;

    assign cur = stage_q[k];

    adder_chunk #(.N(STAGE_BITS)) u_chunk (
      .a_i   (cur.a[k*STAGE_BITS +: STAGE_BITS]),
      .b_i   (cur.b[k*STAGE_BITS +: STAGE_BITS]),
      .cin_i (cur.c),
      .sum_o (csum),
      .cout_o(cco),
      .cmsb_o(cmsb)
    );

    always_comb begin
      nxt                                  = cur;
      nxt.s[k*STAGE_BITS +: STAGE_BITS]    = csum;
      nxt.c                                = cco;
      nxt.ovf                              = cco ^ cmsb;
      // Only the top chunk sees the true MSB carries, so saturation is applied there.
      if ((k == STAGES - 1) && cur.sat && nxt.ovf) begin
        nxt.s = cur.a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end

    assign stage_d[k+1] = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (adv) begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[STAGES].vld;
  assign sum       = stage_q[STAGES].s;
  assign cout      = stage_q[STAGES].c;
  assign ovf       = stage_q[STAGES].ovf;

  logic unused_tail;
  assign unused_tail = ^{stage_q[STAGES].a, stage_q[STAGES].b,
                         stage_q[STAGES].sub, stage_q[STAGES].sat};

endmodule

// File: tb/tb_pipe_adder_sat.sv
// Self-checking bench for pipe_adder_sat (WIDTH=16, STAGE_BITS=4, latency 4).
module tb_pipe_adder_sat;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  pipe_adder_sat #(.WIDTH(16), .STAGE_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sat_en   (sat_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  // Reference: exact integer arithmetic, then range check and saturation.
  function automatic exp_t ref_model(input logic [15:0] x, input logic [15:0] y,
                                     input logic s, input logic st);
    int          sx, sy, exact;
    int unsigned ux, uy, u;
    exp_t        e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = {16'h0, x};
    uy = {16'h0, y};
    if (!s) begin
      exact  = sx + sy;
      u      = ux + uy;
      e.cout = (u > 32'h0000_FFFF);
    end else begin
      exact  = sx - sy;
      u      = ux - uy;
      e.cout = (ux >= uy);
    end
    e.ovf = (exact > 32767) || (exact < -32768);
    e.sum = u[15:0];
    if (st && e.ovf) e.sum = (exact > 0) ? 16'h7FFF : 16'h8000;
    return e;
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h7FFF;
      1: v = 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat_en = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else checks += 0;
    if (out_valid !== 1'b0) failures++;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({sum, cout, ovf} !== 18'h0) begin
      failures++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected 0/0/0", sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [10] = '{16'h1234, 16'hFFFF, 16'h0FFF, 16'h7FFF, 16'h7FFF,
                             16'h8000, 16'h0005, 16'h0007, 16'h8000, 16'h8000};
    logic [15:0] tb [10] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                             16'hFFFF, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
    logic        ts [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic        tt [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    logic [15:0] es [10] = '{16'h1235, 16'h0000, 16'h1000, 16'h8000, 16'h7FFF,
                             16'h8000, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF};
    logic        ec [10] = '{0, 1, 0, 0, 0, 1, 0, 1, 1, 1};
    logic        eo [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    int lat;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[i]; b = tb[i]; sub = ts[i]; sat_en = tt[i]; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_accept: in_ready=%b expected 1", i, in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) lat = c;
      end
      checks++; if (lat !== 4) begin failures++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
      checks++; if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
        failures++;
        $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic        stall_prev;
    logic [17:0] held;
    stall_prev = 1'b0;
    held = '0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      sub       = 1'($urandom_range(0, 1));
      sat_en    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stall_prev) begin
        checks++; if (out_valid !== 1'b1 || {sum, cout, ovf} !== held) begin
          failures++; $display("FAIL rnd_hold t=%0d: got v=%b %h expected v=1 %h", t, out_valid, {sum, cout, ovf}, held);
        end
      end
      checks++; if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL rnd_in_ready t=%0d: got %b expected %b", t, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_unexpected t=%0d: got sum=%h expected no output", t, sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL rnd_result t=%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     t, sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_model(a, b, sub, sat_en));
      stall_prev = out_valid && !out_ready;
      held = {sum, cout, ovf};
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_drain_extra: got sum=%h expected no output", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            failures++; $display("FAIL rnd_drain_result: got %h expected %h", {sum, cout, ovf}, {e.sum, e.cout, e.ovf});
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost: got %0d pending expected 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    int          sent, recv;
    logic        stall_prev;
    logic [17:0] held;
    sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      a         = 16'(sent);
      b         = 16'(sent * 16'h0101);
      sub       = 1'b0;
      sat_en    = 1'b0;
      out_ready = !(t >= 6 && t < 9);
      #1;
      if (!out_ready && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready t=%0d: got %b expected 0", t, in_ready); end
      end
      if (stall_prev) begin
        checks++; if (out_valid !== 1'b1 || {sum, cout, ovf} !== held) begin
          failures++; $display("FAIL b2b_hold t=%0d: got v=%b %h expected v=1 %h", t, out_valid, {sum, cout, ovf}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_duplicate t=%0d: got sum=%h expected no output", t, sum);
        end else begin
          e = q.pop_front();
          recv++;
          if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            failures++; $display("FAIL b2b_result t=%0d: got sum=%h expected sum=%h", t, sum, e.sum);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(a, b, 1'b0, 1'b0));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held = {sum, cout, ovf};
    end
    checks++; if (recv !== 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", recv); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    int stale;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(16'h0100 + i); b = 16'h0001; sub = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
      @(posedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0 || sum !== 16'h0) begin
      failures++; $display("FAIL mid_rst_state: got in_ready=%b sum=%h expected 0/0000", in_ready, sum);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; a = 16'h0042; b = 16'h0001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) lat = c;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_latency: got %0d expected 4", lat); end
    checks++; if (sum !== 16'h0043) begin failures++; $display("FAIL mid_result: got %h expected 0043", sum); end
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale: got %0d extra outputs expected 0", stale); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
